// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the PLL reset sequencer and its environment.
// Build with LOCK_LOSS_COUNT_EN defined to carry the lock-loss counter.
interface pll_reset_sequencer_if;
    // Level signals only, no valid/ready: every output is valid on every cycle,
    // and pll_locked may change at any time relative to clk.
    logic       pll_locked;
    logic       sys_reset;
    logic       ready;
    logic       lock_timeout;
    logic [1:0] state;
`ifdef LOCK_LOSS_COUNT_EN
    logic [7:0] lock_loss_count;

    modport master (
        output pll_locked,
        input  sys_reset, ready, lock_timeout, state, lock_loss_count
    );
    modport slave (
        input  pll_locked,
        output sys_reset, ready, lock_timeout, state, lock_loss_count
    );
`else
    modport master (
        output pll_locked,
        input  sys_reset, ready, lock_timeout, state
    );
    modport slave (
        input  pll_locked,
        output sys_reset, ready, lock_timeout, state
    );
`endif
endinterface

// File: rtl/pll_reset_sequencer.sv
// Turns the PLL lock indication into a qualified system reset with a lock timeout.
// Optional LOCK_LOSS_COUNT_EN macro adds a saturating RUN->WAIT_LOCK event counter.
module pll_reset_sequencer #(
    parameter int SYNC_STAGES    = 2,
    parameter int STABLE_CYCLES  = 1024,
    parameter int HOLD_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int CNT_W          = 24
) (
    input logic                  clk,
    input logic                  reset,
    pll_reset_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_MAX = CNT_W'(TIMEOUT_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       phase_q, phase_d;
    logic [CNT_W-1:0]       timeout_q, timeout_d;
    logic                   timeout_flag_q, timeout_flag_d;
    logic                   locked_s;

    assign sync_d   = {sync_q[SYNC_STAGES-2:0], bus.pll_locked};
    assign locked_s = sync_q[SYNC_STAGES-1];

    // Loss of lock wins over phase completion in every state.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        case (state_q)
            WAIT_LOCK: begin
                phase_d = '0;
                if (locked_s) state_d = STABLE;
            end
            STABLE: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    phase_d = '0;
                end else if (phase_q == STABLE_LAST) begin
                    state_d = HOLD;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            HOLD: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    phase_d = '0;
                end else if (phase_q == HOLD_LAST) begin
                    state_d = RUN;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            RUN: begin
                phase_d = '0;
                if (!locked_s) state_d = WAIT_LOCK;
            end
            default: begin
                state_d = WAIT_LOCK;
                phase_d = '0;
            end
        endcase
    end

    // Window restarts each time RUN is reached; the flag itself is sticky.
    always_comb begin
        timeout_d = timeout_q;
        if (state_q == RUN || state_d == RUN) begin
            timeout_d = '0;
        end else if (timeout_q != TIMEOUT_MAX) begin
            timeout_d = timeout_q + 1'b1;
        end
        timeout_flag_d = timeout_flag_q | (timeout_d == TIMEOUT_MAX);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q         <= '0;
            state_q        <= WAIT_LOCK;
            phase_q        <= '0;
            timeout_q      <= '0;
            timeout_flag_q <= 1'b0;
        end else begin
            sync_q         <= sync_d;
            state_q        <= state_d;
            phase_q        <= phase_d;
            timeout_q      <= timeout_d;
            timeout_flag_q <= timeout_flag_d;
        end
    end

`ifdef LOCK_LOSS_COUNT_EN
    logic [7:0] loss_cnt_q, loss_cnt_d;

    always_comb begin
        loss_cnt_d = loss_cnt_q;
        if (state_q == RUN && state_d == WAIT_LOCK && loss_cnt_q != 8'hFF) begin
            loss_cnt_d = loss_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) loss_cnt_q <= '0;
        else       loss_cnt_q <= loss_cnt_d;
    end

    assign bus.lock_loss_count = loss_cnt_q;
`endif

    assign bus.state        = state_q;
    assign bus.sys_reset    = (state_q != RUN);
    assign bus.ready        = (state_q == RUN);
    assign bus.lock_timeout = timeout_flag_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer: timed expectations go into a queue,
// a negedge monitor pops and compares them against the live outputs.
module tb_pll_reset_sequencer;

    localparam int EXP_W = 33;  // {edge[19:0], state[1:0], sys_reset, ready, lock_timeout, count[7:0]}

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pll_reset_sequencer_if bif ();

    pll_reset_sequencer #(
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (8),
        .HOLD_CYCLES   (4),
        .TIMEOUT_CYCLES(64),
        .CNT_W         (24)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bif)
    );

    int unsigned cyc = 0;
    int unsigned base = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    logic [EXP_W-1:0] exp_q[$];
    string            name_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard helpers ----------------
    task automatic expect_at(input string nm, input int unsigned k, input logic [1:0] st,
                             input logic to, input logic [7:0] cnt);
        logic [EXP_W-1:0] w;
        logic [19:0]      e;
        e = 20'(base + k);
        w = {e, st, (st != 2'd3), (st == 2'd3), to, cnt};
        exp_q.push_back(w);
        name_q.push_back(nm);
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick_to(input int unsigned k);
        while (cyc < base + k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input logic lk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        bif.pll_locked = lk;
        base = cyc;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        logic [EXP_W-1:0] w;
        logic [12:0]      act;
        logic [12:0]      mask;
        logic [7:0]       act_cnt;
        string            nm;
`ifdef LOCK_LOSS_COUNT_EN
        act_cnt = bif.lock_loss_count;
        mask    = 13'h1FFF;
`else
        act_cnt = 8'd0;
        mask    = 13'h1F00;
`endif
        while (exp_q.size() != 0 && exp_q[0][32:13] <= cyc[19:0]) begin
            w  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_checks++;
            if (w[32:13] != cyc[19:0]) begin
                $display("FAIL %s: expectation for edge %0d not reached in time (now %0d)",
                         nm, w[32:13], cyc);
            end else begin
                act = {bif.state, bif.sys_reset, bif.ready, bif.lock_timeout, act_cnt};
                if (((act ^ w[12:0]) & mask) == 13'd0) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s @edge %0d: got state=%0d sys_reset=%0b ready=%0b timeout=%0b cnt=%0d, want state=%0d sys_reset=%0b ready=%0b timeout=%0b cnt=%0d",
                             nm, cyc - base, act[12:11], act[10], act[9], act[8], act[7:0],
                             w[12:11], w[10], w[9], w[8], w[7:0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        bif.pll_locked = 1'b0;

        // Scenario 1: clean lock from reset release
        do_reset(1'b1);
        expect_at("s1_reset",      0, 2'd0, 1'b0, 8'd0);
        expect_at("s1_sync",       2, 2'd0, 1'b0, 8'd0);
        expect_at("s1_stable",     3, 2'd1, 1'b0, 8'd0);
        expect_at("s1_stable_end", 10, 2'd1, 1'b0, 8'd0);
        expect_at("s1_hold",       11, 2'd2, 1'b0, 8'd0);
        expect_at("s1_hold_end",   14, 2'd2, 1'b0, 8'd0);
        expect_at("s1_run",        15, 2'd3, 1'b0, 8'd0);
        expect_at("s1_run_steady", 30, 2'd3, 1'b0, 8'd0);
        tick_to(31);

        // Scenario 2: one-cycle glitch during STABLE restarts qualification
        do_reset(1'b1);
        expect_at("s2_reset",       0, 2'd0, 1'b0, 8'd0);
        expect_at("s2_stable",      3, 2'd1, 1'b0, 8'd0);
        expect_at("s2_pre_glitch",  7, 2'd1, 1'b0, 8'd0);
        expect_at("s2_glitch_wait", 8, 2'd0, 1'b0, 8'd0);
        expect_at("s2_restable",    9, 2'd1, 1'b0, 8'd0);
        expect_at("s2_stable_end",  16, 2'd1, 1'b0, 8'd0);
        expect_at("s2_hold",        17, 2'd2, 1'b0, 8'd0);
        expect_at("s2_hold_end",    20, 2'd2, 1'b0, 8'd0);
        expect_at("s2_run",         21, 2'd3, 1'b0, 8'd0);
        tick_to(5);
        bif.pll_locked = 1'b0;
        tick_to(6);
        bif.pll_locked = 1'b1;
        tick_to(22);

        // Scenario 3: lock loss in RUN, then relock
        do_reset(1'b1);
        expect_at("s3_run",        15, 2'd3, 1'b0, 8'd0);
        expect_at("s3_still_run",  22, 2'd3, 1'b0, 8'd0);
        expect_at("s3_loss",       23, 2'd0, 1'b0, 8'd1);
        expect_at("s3_wait",       25, 2'd0, 1'b0, 8'd1);
        expect_at("s3_restable",   26, 2'd1, 1'b0, 8'd1);
        expect_at("s3_hold_end",   37, 2'd2, 1'b0, 8'd1);
        expect_at("s3_rerun",      38, 2'd3, 1'b0, 8'd1);
        tick_to(20);
        bif.pll_locked = 1'b0;
        tick_to(23);
        bif.pll_locked = 1'b1;
        tick_to(40);

        // Scenario 4: no lock -> timeout, sticky through a later lock
        do_reset(1'b0);
        expect_at("s4_reset",      0, 2'd0, 1'b0, 8'd0);
        expect_at("s4_pre_to",     63, 2'd0, 1'b0, 8'd0);
        expect_at("s4_to",         64, 2'd0, 1'b1, 8'd0);
        expect_at("s4_to_sat",     100, 2'd0, 1'b1, 8'd0);
        expect_at("s4_stable",     103, 2'd1, 1'b1, 8'd0);
        expect_at("s4_hold",       111, 2'd2, 1'b1, 8'd0);
        expect_at("s4_run",        115, 2'd3, 1'b1, 8'd0);
        expect_at("s4_run_sticky", 130, 2'd3, 1'b1, 8'd0);
        tick_to(100);
        bif.pll_locked = 1'b1;
        tick_to(131);

        // Scenario 5: reset pulse in HOLD restarts everything
        do_reset(1'b1);
        expect_at("s5_reset_clr", 0, 2'd0, 1'b0, 8'd0);
        expect_at("s5_hold",      11, 2'd2, 1'b0, 8'd0);
        expect_at("s5_mid_reset", 12, 2'd0, 1'b0, 8'd0);
        expect_at("s5_resync",    14, 2'd0, 1'b0, 8'd0);
        expect_at("s5_stable",    15, 2'd1, 1'b0, 8'd0);
        expect_at("s5_stab_end",  22, 2'd1, 1'b0, 8'd0);
        expect_at("s5_hold2",     23, 2'd2, 1'b0, 8'd0);
        expect_at("s5_run",       27, 2'd3, 1'b0, 8'd0);
        tick_to(11);
        reset = 1'b1;
        tick_to(12);
        reset = 1'b0;
        tick_to(28);

`ifdef LOCK_LOSS_COUNT_EN
        // Scenario 6: counter saturation over 300 loss/relock episodes
        begin
            int unsigned r;
            logic [7:0]  exp_cnt;
            do_reset(1'b1);
            r = 15;
            expect_at("s6_run0", r, 2'd3, 1'b0, 8'd0);
            for (int i = 0; i < 300; i++) begin
                exp_cnt = (i + 1 > 255) ? 8'd255 : 8'(i + 1);
                tick_to(r);
                bif.pll_locked = 1'b0;
                expect_at("s6_loss", r + 3, 2'd0, 1'b0, exp_cnt);
                expect_at("s6_rerun", r + 18, 2'd3, 1'b0, exp_cnt);
                tick_to(r + 3);
                bif.pll_locked = 1'b1;
                r = r + 18;
            end
            tick_to(r + 1);
            do_reset(1'b1);
            expect_at("s6_cnt_clr", 0, 2'd0, 1'b0, 8'd0);
            tick_to(2);
        end
`endif

        tick_to(cyc - base + 4);
        if (exp_q.size() != 0) begin
            $display("FAIL drain: %0d expectations never checked", exp_q.size());
            n_checks = n_checks + exp_q.size();
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
